pcap_arm_ctrl: RTL and testbench

Arming and run-sequencing controller for the position-capture core. It turns the `ARM`/`DISARM` register strobes and the `enable_i` bit-bus level into a single capture run, and gates the datapath enable. It terminates the run on normal end, user disarm, framing error or DMA overflow, waits for the DMA path to flush, and reports a completion code. It sits between the register interface and `pcap_core`, and drives the core's run-control inputs plus the `pcap_actv_o`/`pcap_done_o`/`pcap_status_o`/`HEALTH` outputs.

---
 rtl/pcap_ctrl_pkg.sv | 30 +++
 rtl/pcap_flush_timer.sv | 39 +++
 rtl/pcap_arm_ctrl.sv | 116 +++++++++++
 tb/tb_pcap_arm_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pcap_ctrl_pkg.sv
// Shared types and completion codes for the position-capture run controller.
package pcap_ctrl_pkg;

  // Run-sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_ENABLED = 2'd2,
    ST_FLUSH   = 2'd3
  } state_e;

  // Completion codes reported on pcap_status_o / HEALTH.
  localparam logic [2:0] CODE_OK        = 3'd0;
  localparam logic [2:0] CODE_DISARMED  = 3'd1;
  localparam logic [2:0] CODE_TOO_CLOSE = 3'd2;
  localparam logic [2:0] CODE_OVERFLOW  = 3'd3;
  localparam logic [2:0] CODE_TIMEOUT   = 3'd4;

  // Highest-priority exit cause while ENABLED; falls through to OK when
  // the only cause left is enable_i dropping.
  function automatic logic [2:0] exit_code(input logic dma_full,
                                           input logic frame_err,
                                           input logic disarm);
    if (dma_full)       return CODE_OVERFLOW;
    else if (frame_err) return CODE_TOO_CLOSE;
    else if (disarm)    return CODE_DISARMED;
    else                return CODE_OK;
  endfunction

endpackage

// File: rtl/pcap_flush_timer.sv
// Saturating cycle counter bounding the time spent waiting for the DMA flush.
// 'expired' is high in the FLUSH_TIMEOUT-th cycle of a run of 'run' cycles.
module pcap_flush_timer #(
  parameter int unsigned FLUSH_TIMEOUT = 125000
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned CW = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(FLUSH_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up while running and hold at LAST.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = run && !clear && (cnt_q == LAST);

endmodule

// File: rtl/pcap_arm_ctrl.sv
// Arming / run-sequencing controller: turns ARM/DISARM strobes and the
// enable level into one capture run, latches the first exit cause, waits for
// the DMA flush (bounded by a timeout) and pulses done. All outputs are
// registered; dbg_state_o exposes the FSM state.
module pcap_arm_ctrl
  import pcap_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_TIMEOUT = 125000
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        ARM,
  input  logic        DISARM,
  input  logic        enable_i,
  input  logic        frame_error_i,
  input  logic        dma_full_i,
  input  logic        flush_done_i,
  output logic        pcap_start_o,
  output logic        pcap_enable_o,
  output logic        pcap_actv_o,
  output logic        pcap_done_o,
  output logic [2:0]  pcap_status_o,
  output logic [31:0] HEALTH,
  output state_e      dbg_state_o
);

  state_e     state_q, state_d;
  logic [2:0] status_q, status_d;
  logic       start_q, start_d;
  logic       done_q, done_d;
  logic       enable_q, actv_q;
  logic       timer_expired;

  pcap_flush_timer #(
    .FLUSH_TIMEOUT(FLUSH_TIMEOUT)
  ) u_flush_timer (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .clear    (state_q != ST_FLUSH),
    .run      (state_q == ST_FLUSH),
    .expired  (timer_expired)
  );

  // Next-state, status latch and one-cycle pulse decode.
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    start_d  = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A simultaneous DISARM vetoes the ARM.
        if (ARM && !DISARM) begin
          state_d  = ST_ARMED;
          start_d  = 1'b1;
          status_d = CODE_OK;
        end
      end
      ST_ARMED: begin
        if (DISARM) begin
          state_d  = ST_FLUSH;
          status_d = CODE_DISARMED;
        end else if (enable_i) begin
          state_d = ST_ENABLED;
        end
      end
      ST_ENABLED: begin
        if (dma_full_i || frame_error_i || DISARM || !enable_i) begin
          state_d  = ST_FLUSH;
          status_d = exit_code(dma_full_i, frame_error_i, DISARM);
        end
      end
      ST_FLUSH: begin
        // flush_done beats a coincident timeout and keeps the latched cause.
        if (flush_done_i) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (timer_expired) begin
          state_d  = ST_IDLE;
          status_d = CODE_TIMEOUT;
          done_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; enable/actv are decoded from the next state
  // so they change on the same edge as the state.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= ST_IDLE;
      status_q <= CODE_OK;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      enable_q <= 1'b0;
      actv_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      start_q  <= start_d;
      done_q   <= done_d;
      enable_q <= (state_d == ST_ENABLED);
      actv_q   <= (state_d != ST_IDLE);
    end
  end

  assign pcap_start_o  = start_q;
  assign pcap_enable_o = enable_q;
  assign pcap_actv_o   = actv_q;
  assign pcap_done_o   = done_q;
  assign pcap_status_o = status_q;
  assign HEALTH        = {29'b0, status_q};
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_pcap_arm_ctrl.sv
// Directed bench for pcap_arm_ctrl. Cycle N is the interval after the N-th
// rising edge of the current test; inputs set in cycle N are sampled at the
// edge that starts cycle N+1. Expected done cycle/status are queued when the
// run-ending stimulus is driven and popped when pcap_done_o is seen.
module tb_pcap_arm_ctrl;
  import pcap_ctrl_pkg::*;

  // Long enough that the 19-cycle flush of the normal run does not time out.
  localparam int TB_TO = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic arm = 1'b0, disarm = 1'b0, enable = 1'b0;
  logic frame_err = 1'b0, dma_full = 1'b0, flush_done = 1'b0;
  logic start_o, enable_o, actv_o, done_o;
  logic [2:0] status_o;
  logic [31:0] health_o;
  state_e dbg_state;

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;

  logic [2:0] exp_q[$];
  int exp_cyc_q[$];
  logic [2:0] e_stat;
  int e_cyc;

  int st_cnt, st_cyc, en_cnt, en_first, en_last, av_cnt, av_first, av_last;

  pcap_arm_ctrl #(.FLUSH_TIMEOUT(TB_TO)) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .ARM          (arm),
    .DISARM       (disarm),
    .enable_i     (enable),
    .frame_error_i(frame_err),
    .dma_full_i   (dma_full),
    .flush_done_i (flush_done),
    .pcap_start_o (start_o),
    .pcap_enable_o(enable_o),
    .pcap_actv_o  (actv_o),
    .pcap_done_o  (done_o),
    .pcap_status_o(status_o),
    .HEALTH       (health_o),
    .dbg_state_o  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic new_test();
    cyc = 0;
    st_cnt = 0; st_cyc = -1;
    en_cnt = 0; en_first = -1; en_last = -1;
    av_cnt = 0; av_first = -1; av_last = -1;
  endtask

  task automatic expect_done(input logic [2:0] code, input int c);
    exp_q.push_back(code);
    exp_cyc_q.push_back(c);
  endtask

  // Per-run output tracker and done scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (start_o) begin st_cnt++; st_cyc = cyc; end
    if (enable_o) begin if (en_cnt == 0) en_first = cyc; en_last = cyc; en_cnt++; end
    if (actv_o) begin if (av_cnt == 0) av_first = cyc; av_last = cyc; av_cnt++; end
    if (done_o) begin
      check("done_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e_stat = exp_q.pop_front();
        e_cyc  = exp_cyc_q.pop_front();
        check("done_cycle", cyc, e_cyc);
        check("done_status", status_o, e_stat);
        check("done_health", health_o, {29'b0, e_stat});
      end
    end
  end

  // ENABLED exit with a given set of causes at cycle 50; ARM at 30 must be ignored.
  task automatic prio_run(input logic df, input logic fe, input logic ds,
                          input logic [2:0] code, input string tag);
    new_test();
    goto(10); arm = 1;
    goto(11); arm = 0;
    goto(20); enable = 1;
    goto(30); arm = 1;
    goto(31); arm = 0;
    goto(50); dma_full = df; frame_err = fe; disarm = ds; expect_done(code, 61);
    goto(51); dma_full = 0; frame_err = 0; disarm = 0;
    check({tag, "_enable_off"}, enable_o, 0);
    check({tag, "_actv_flush"}, actv_o, 1);
    goto(55); enable = 0; frame_err = 1;
    goto(56); frame_err = 0;
    goto(60); flush_done = 1;
    goto(61); flush_done = 0;
    goto(64);
    check({tag, "_start_count"}, st_cnt, 1);
    check({tag, "_enable_last"}, en_last, 50);
  endtask

  initial begin
    #1 reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_start", start_o, 0);
    check("rst_enable", enable_o, 0);
    check("rst_actv", actv_o, 0);
    check("rst_done", done_o, 0);
    check("rst_status", status_o, 0);
    check("rst_health", health_o, 0);
    reset_n = 1;

    // Normal run
    new_test();
    goto(10); arm = 1; expect_done(CODE_OK, 121);
    goto(11); arm = 0;
    check("t1_start", start_o, 1);
    check("t1_actv", actv_o, 1);
    goto(12); check("t1_start_low", start_o, 0);
    goto(20); enable = 1;
    goto(101); enable = 0;
    goto(120); flush_done = 1;
    goto(121); flush_done = 0;
    goto(124);
    check("t1_start_count", st_cnt, 1);
    check("t1_start_cycle", st_cyc, 11);
    check("t1_enable_first", en_first, 21);
    check("t1_enable_last", en_last, 101);
    check("t1_actv_first", av_first, 11);
    check("t1_actv_last", av_last, 120);

    // Disarm while ARMED
    new_test();
    goto(10); arm = 1;
    goto(11); arm = 0;
    goto(15); disarm = 1; expect_done(CODE_DISARMED, 21);
    goto(16); disarm = 0;
    check("t2_actv_flush", actv_o, 1);
    goto(20); flush_done = 1;
    goto(21); flush_done = 0;
    goto(24);
    check("t2_enable_never", en_cnt, 0);
    check("t2_actv_last", av_last, 20);

    // Exit-cause priority
    prio_run(1, 1, 1, CODE_OVERFLOW, "t3_all");
    prio_run(0, 1, 1, CODE_TOO_CLOSE, "t3_fe_ds");
    prio_run(0, 0, 1, CODE_DISARMED, "t3_ds");

    // Flush timeout: exit at 40, FLUSH from 41 for TB_TO cycles
    new_test();
    goto(10); arm = 1;
    goto(11); arm = 0;
    goto(20); enable = 1;
    goto(40); enable = 0; expect_done(CODE_TIMEOUT, 41 + TB_TO);
    goto(50); dma_full = 1;
    goto(51); dma_full = 0;
    goto(44 + TB_TO);
    check("t4_status", status_o, CODE_TIMEOUT);
    check("t4_health", health_o, 4);
    check("t4_actv_last", av_last, 40 + TB_TO);

    // ARM+DISARM and DISARM alone in IDLE; status held
    new_test();
    goto(5); disarm = 1;
    goto(6); disarm = 0;
    goto(10); arm = 1; disarm = 1;
    goto(11); arm = 0; disarm = 0;
    check("t5_actv", actv_o, 0);
    check("t5_start", start_o, 0);
    goto(14);
    check("t5_start_count", st_cnt, 0);
    check("t5_health_held", health_o, 4);

    // Next accepted ARM clears HEALTH, then reset mid-run
    goto(20); arm = 1;
    goto(21); arm = 0;
    check("t6_health_clear", health_o, 0);
    check("t6_start", start_o, 1);
    goto(25); enable = 1;
    goto(60);
    check("t6_enabled", enable_o, 1);
    reset_n = 0;
    #1;
    check("t6_rst_enable", enable_o, 0);
    check("t6_rst_actv", actv_o, 0);
    check("t6_rst_start", start_o, 0);
    check("t6_rst_done", done_o, 0);
    check("t6_rst_health", health_o, 0);
    enable = 0;
    tick(); tick();
    reset_n = 1;

    // Fresh run after reset
    new_test();
    goto(10); arm = 1;
    goto(11); arm = 0;
    check("t7_start", start_o, 1);
    goto(20); enable = 1;
    goto(30); enable = 0;
    goto(40); flush_done = 1; expect_done(CODE_OK, 41);
    goto(41); flush_done = 0;
    goto(44);
    check("t7_start_count", st_cnt, 1);
    check("t7_enable_first", en_first, 21);
    check("t7_enable_last", en_last, 30);

    check("pending_done", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
